// File: rtl/drive_cmd_decoder_if.sv
// rtl/drive_cmd_decoder_if.sv - command byte input, servo/motor outputs and status byte stream of the drive decoder
interface drive_cmd_if #(
    parameter int ANGLE_W = 8
);
    logic               rx_finish;
    logic               rx_error;
    logic [7:0]         rx_data;
    logic [ANGLE_W-1:0] angle;
    logic [1:0]         direction;
    logic               cmd_strobe;
    logic               wdt_trip;
    logic               ack_valid;
    logic               ack_ready;
    logic [7:0]         ack_data;

    modport master (
        output rx_finish, rx_error, rx_data, ack_ready,
        input  angle, direction, cmd_strobe, wdt_trip, ack_valid, ack_data
    );

    modport slave (
        input  rx_finish, rx_error, rx_data, ack_ready,
        output angle, direction, cmd_strobe, wdt_trip, ack_valid, ack_data
    );
endinterface

// File: rtl/drive_cmd_decoder.sv
// rtl/drive_cmd_decoder.sv - UART command decoder for servo angle and motor direction with watchdog
// Optional status byte return enabled by defining DRIVE_CMD_ACK_EN.
module drive_cmd_decoder #(
    parameter int ANGLE_W       = 8,
    parameter int MIN_ANGLE     = 195,
    parameter int MAX_ANGLE     = 255,
    parameter int DEFAULT_ANGLE = 225,
    parameter int STEP          = 1,
    parameter int WDT_CYCLES    = 50_000_000,
    parameter int SYNC_STAGES   = 3
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    drive_cmd_if.slave  bus
);

    localparam logic [ANGLE_W:0]   MIN_E   = (ANGLE_W+1)'(MIN_ANGLE);
    localparam logic [ANGLE_W:0]   MAX_E   = (ANGLE_W+1)'(MAX_ANGLE);
    localparam logic [ANGLE_W:0]   STEP_E  = (ANGLE_W+1)'(STEP);
    localparam logic [ANGLE_W-1:0] DEF_A   = ANGLE_W'(DEFAULT_ANGLE);
    localparam int                 WDT_W   = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0]   WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    localparam logic [1:0]         DIR_FWD  = 2'b11;
    localparam logic [1:0]         DIR_BWD  = 2'b00;
    localparam logic [1:0]         DIR_HALT = 2'b01;

    typedef enum logic {IDLE, ABS_WAIT} state_t;

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] fin_sync, err_sync;
    logic               fin_last_q;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic [1:0]         dir_q, dir_d;
    logic               strobe_q, trip_q, trip_d;
    logic [WDT_W-1:0]   wdt_q, wdt_d;
    logic               accept, saturated, absolute;
    logic               byte_event, byte_err;
    logic [ANGLE_W:0]   angle_ext, up_sum, dn_diff, abs_ext;

    assign byte_event = fin_sync[SYNC_STAGES-1] & ~fin_last_q;
    assign byte_err   = err_sync[SYNC_STAGES-1];
    assign angle_ext  = {1'b0, angle_q};
    assign up_sum     = angle_ext + STEP_E;
    assign dn_diff    = angle_ext - STEP_E;
    assign abs_ext    = {{(ANGLE_W-7){1'b0}}, bus.rx_data};

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_sync   <= '0;
            err_sync   <= '0;
            fin_last_q <= 1'b0;
            state_q    <= IDLE;
            angle_q    <= DEF_A;
            dir_q      <= DIR_HALT;
            strobe_q   <= 1'b0;
            trip_q     <= 1'b0;
            wdt_q      <= '0;
        end else begin
            fin_sync   <= {fin_sync[SYNC_STAGES-2:0], bus.rx_finish};
            err_sync   <= {err_sync[SYNC_STAGES-2:0], bus.rx_error};
            fin_last_q <= fin_sync[SYNC_STAGES-1];
            state_q    <= state_d;
            angle_q    <= angle_d;
            dir_q      <= dir_d;
            strobe_q   <= accept;
            trip_q     <= trip_d;
            wdt_q      <= wdt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        angle_d   = angle_q;
        dir_d     = dir_q;
        accept    = 1'b0;
        saturated = 1'b0;
        absolute  = 1'b0;
        trip_d    = 1'b0;
        wdt_d     = wdt_q;

        if (byte_event) begin
            if (byte_err) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        case (bus.rx_data[1:0])
                            2'b00: begin
                                accept = 1'b1;
                                case (bus.rx_data[7:5])
                                    3'b011:  dir_d = DIR_FWD;
                                    3'b110:  dir_d = DIR_BWD;
                                    default: dir_d = DIR_HALT;
                                endcase
                                case (bus.rx_data[4:2])
                                    3'b011: begin
                                        if (up_sum > MAX_E) begin
                                            angle_d   = MAX_E[ANGLE_W-1:0];
                                            saturated = 1'b1;
                                        end else begin
                                            angle_d = up_sum[ANGLE_W-1:0];
                                        end
                                    end
                                    3'b110: begin
                                        // Compare before subtracting so a large STEP cannot wrap below zero.
                                        if (angle_ext < STEP_E || dn_diff < MIN_E) begin
                                            angle_d   = MIN_E[ANGLE_W-1:0];
                                            saturated = 1'b1;
                                        end else begin
                                            angle_d = dn_diff[ANGLE_W-1:0];
                                        end
                                    end
                                    3'b101:  angle_d = DEF_A;
                                    default: angle_d = angle_q;
                                endcase
                            end
                            2'b01:   state_d = ABS_WAIT;
                            default: state_d = IDLE;
                        endcase
                    end
                    ABS_WAIT: begin
                        accept   = 1'b1;
                        absolute = 1'b1;
                        state_d  = IDLE;
                        if (abs_ext < MIN_E) begin
                            angle_d   = MIN_E[ANGLE_W-1:0];
                            saturated = 1'b1;
                        end else if (abs_ext > MAX_E) begin
                            angle_d   = MAX_E[ANGLE_W-1:0];
                            saturated = 1'b1;
                        end else begin
                            angle_d = abs_ext[ANGLE_W-1:0];
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // An accepted command outranks expiry in the same cycle.
        if (accept || dir_q == DIR_HALT || WDT_CYCLES == 0) begin
            wdt_d = '0;
        end else if (wdt_q == WDT_LAST) begin
            dir_d  = DIR_HALT;
            trip_d = 1'b1;
            wdt_d  = '0;
        end else begin
            wdt_d = wdt_q + WDT_W'(1);
        end
    end

    assign bus.angle      = angle_q;
    assign bus.direction  = dir_q;
    assign bus.cmd_strobe = strobe_q;
    assign bus.wdt_trip   = trip_q;

`ifdef DRIVE_CMD_ACK_EN
    logic       ack_valid_q;
    logic [7:0] ack_data_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_valid_q <= 1'b0;
            ack_data_q  <= 8'h00;
        end else if (accept) begin
            ack_valid_q <= 1'b1;
            ack_data_q  <= {dir_d, saturated, absolute, 4'h5};
        end else if (trip_d) begin
            ack_valid_q <= 1'b1;
            ack_data_q  <= {2'b01, 2'b00, 4'hE};
        end else if (ack_valid_q && bus.ack_ready) begin
            ack_valid_q <= 1'b0;
        end
    end

    assign bus.ack_valid = ack_valid_q;
    assign bus.ack_data  = ack_data_q;
`else
    logic ack_ready_unused;
    logic ack_flags_unused;

    assign ack_ready_unused = bus.ack_ready;
    assign ack_flags_unused = saturated ^ absolute;
    assign bus.ack_valid    = 1'b0;
    assign bus.ack_data     = 8'h00;
`endif

endmodule

// File: tb/tb_drive_cmd_decoder.sv
// tb/tb_drive_cmd_decoder.sv - directed self-checking bench for drive_cmd_decoder
module tb_drive_cmd_decoder;

    logic sys_clk;
    logic rst_n;
    int   checks;
    int   errors;

    drive_cmd_if #(.ANGLE_W(8)) bus ();

    drive_cmd_decoder #(
        .ANGLE_W(8), .MIN_ANGLE(195), .MAX_ANGLE(255), .DEFAULT_ANGLE(225),
        .STEP(1), .WDT_CYCLES(100), .SYNC_STAGES(3)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

`ifdef DRIVE_CMD_ACK_EN
    localparam logic ACK_ON = 1'b1;
`else
    localparam logic ACK_ON = 1'b0;
`endif

    function automatic logic [7:0] ack_exp(input logic [7:0] v);
        return ACK_ON ? v : 8'h00;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic err,
                             output logic s3, output logic s4, output int nstr);
        @(negedge sys_clk);
        bus.rx_data   = b;
        bus.rx_error  = err;
        bus.rx_finish = 1'b1;
        nstr = 0; s3 = 1'b0; s4 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge sys_clk); #1;
            if (bus.cmd_strobe) nstr++;
            if (k == 3) s3 = bus.cmd_strobe;
            if (k == 4) s4 = bus.cmd_strobe;
        end
        @(negedge sys_clk);
        bus.rx_finish = 1'b0;
        bus.rx_error  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge sys_clk); #1;
            if (bus.cmd_strobe) nstr++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.rx_finish = 1'b0; bus.rx_error = 1'b0; bus.rx_data = 8'h00; bus.ack_ready = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++; if (bus.angle !== 8'd225) begin errors++; $display("FAIL reset_angle got %0d want 225", bus.angle); end
        checks++; if (bus.direction !== 2'b01) begin errors++; $display("FAIL reset_dir got %b want 01", bus.direction); end
        checks++; if (bus.cmd_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", bus.cmd_strobe); end
        checks++; if (bus.wdt_trip !== 1'b0) begin errors++; $display("FAIL reset_trip got %b want 0", bus.wdt_trip); end
        checks++; if (bus.ack_valid !== 1'b0 || bus.ack_data !== 8'h00) begin
            errors++; $display("FAIL reset_ack got %b/%h want 0/00", bus.ack_valid, bus.ack_data); end
        @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);
    endtask

    task automatic test_relative;
        logic s3, s4; int n;
        send_byte(8'h6C, 1'b0, s3, s4, n);
        checks++; if (s3 !== 1'b0 || s4 !== 1'b1) begin errors++; $display("FAIL rel_latency got s3=%b s4=%b want 0 1", s3, s4); end
        checks++; if (n !== 1) begin errors++; $display("FAIL rel_strobes got %0d want 1", n); end
        checks++; if (bus.angle !== 8'd226) begin errors++; $display("FAIL rel_angle got %0d want 226", bus.angle); end
        checks++; if (bus.direction !== 2'b11) begin errors++; $display("FAIL rel_dir got %b want 11", bus.direction); end
        checks++; if (bus.ack_data !== ack_exp(8'hC5) || bus.ack_valid !== ACK_ON) begin
            errors++; $display("FAIL rel_ack got %b/%h want %b/%h", bus.ack_valid, bus.ack_data, ACK_ON, ack_exp(8'hC5)); end
    endtask

    task automatic test_saturation;
        logic s3, s4; int n, total;
        logic [7:0] seq   [7] = '{8'h01, 8'hFF, 8'h0C, 8'h18, 8'h01, 8'hC4, 8'h18};
        logic [7:0] exp_a [7] = '{8'd226, 8'd255, 8'd255, 8'd254, 8'd254, 8'd196, 8'd195};
        logic [7:0] exp_k [7] = '{8'hC5, 8'hD5, 8'h65, 8'h45, 8'h45, 8'h55, 8'h45};
        total = 0;
        for (int i = 0; i < 7; i++) begin
            send_byte(seq[i], 1'b0, s3, s4, n);
            total += n;
            checks++; if (bus.angle !== exp_a[i] || bus.ack_data !== ack_exp(exp_k[i])) begin
                errors++; $display("FAIL sat_step%0d got angle %0d ack %h want %0d %h", i, bus.angle, bus.ack_data, exp_a[i], ack_exp(exp_k[i])); end
        end
        checks++; if (total !== 5) begin errors++; $display("FAIL sat_strobes got %0d want 5", total); end
        send_byte(8'h18, 1'b0, s3, s4, n);
        checks++; if (bus.angle !== 8'd195 || bus.ack_data !== ack_exp(8'h65)) begin
            errors++; $display("FAIL sat_min got angle %0d ack %h want 195 %h", bus.angle, bus.ack_data, ack_exp(8'h65)); end
    endtask

    task automatic test_absolute;
        logic s3, s4; int n, total;
        send_byte(8'h74, 1'b0, s3, s4, n);
        checks++; if (bus.angle !== 8'd225 || bus.direction !== 2'b11) begin
            errors++; $display("FAIL abs_setup got %0d/%b want 225/11", bus.angle, bus.direction); end
        send_byte(8'h01, 1'b0, s3, s4, n);
        total = n;
        send_byte(8'h10, 1'b0, s3, s4, n);
        total += n;
        checks++; if (total !== 1) begin errors++; $display("FAIL abs_strobes got %0d want 1", total); end
        checks++; if (bus.angle !== 8'd195) begin errors++; $display("FAIL abs_clamp got %0d want 195", bus.angle); end
        checks++; if (bus.direction !== 2'b11) begin errors++; $display("FAIL abs_dir got %b want 11", bus.direction); end
        checks++; if (bus.ack_data !== ack_exp(8'hF5)) begin errors++; $display("FAIL abs_ack got %h want %h", bus.ack_data, ack_exp(8'hF5)); end
        send_byte(8'h01, 1'b0, s3, s4, n);
        send_byte(8'hC8, 1'b0, s3, s4, n);
        checks++; if (bus.angle !== 8'd200 || bus.ack_data !== ack_exp(8'hD5)) begin
            errors++; $display("FAIL abs_inrange got %0d %h want 200 %h", bus.angle, bus.ack_data, ack_exp(8'hD5)); end
        send_byte(8'h14, 1'b0, s3, s4, n);
    endtask

    task automatic test_error;
        logic s3, s4; int n, total;
        send_byte(8'h6C, 1'b0, s3, s4, n);
        send_byte(8'h01, 1'b0, s3, s4, n);
        total = n;
        send_byte(8'hFF, 1'b1, s3, s4, n);
        total += n;
        checks++; if (bus.angle !== 8'd226) begin errors++; $display("FAIL err_discard got %0d want 226", bus.angle); end
        send_byte(8'h6E, 1'b0, s3, s4, n);
        total += n;
        checks++; if (total !== 0 || bus.angle !== 8'd226) begin
            errors++; $display("FAIL err_ignored got strobes %0d angle %0d want 0 226", total, bus.angle); end
        send_byte(8'h14, 1'b0, s3, s4, n);
        checks++; if (n !== 1 || bus.angle !== 8'd225 || bus.direction !== 2'b01) begin
            errors++; $display("FAIL err_recover got %0d/%0d/%b want 1/225/01", n, bus.angle, bus.direction); end
    endtask

    task automatic test_watchdog;
        logic s3, s4; int n, trips, trip_at;
        logic [1:0] dir99; logic st100, tr100;
        @(negedge sys_clk);
        bus.rx_data = 8'h60; bus.rx_finish = 1'b1;
        s4 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge sys_clk); #1;
            if (k == 4) s4 = bus.cmd_strobe;
        end
        @(negedge sys_clk);
        bus.rx_finish = 1'b0;
        checks++; if (s4 !== 1'b1 || bus.direction !== 2'b11) begin
            errors++; $display("FAIL wdt_start got strobe %b dir %b want 1 11", s4, bus.direction); end
        trips = 0; trip_at = -1; dir99 = 2'bxx;
        for (n = 5; n <= 130; n++) begin
            @(posedge sys_clk); #1;
            if (bus.wdt_trip) begin trips++; trip_at = n; end
            if (n == 99) dir99 = bus.direction;
        end
        checks++; if (dir99 !== 2'b11) begin errors++; $display("FAIL wdt_before got %b want 11", dir99); end
        checks++; if (trips !== 1 || trip_at !== 100) begin
            errors++; $display("FAIL wdt_trip got %0d trips at %0d want 1 at 100", trips, trip_at); end
        checks++; if (bus.direction !== 2'b01 || bus.angle !== 8'd225) begin
            errors++; $display("FAIL wdt_halt got %b/%0d want 01/225", bus.direction, bus.angle); end
        checks++; if (bus.ack_data !== ack_exp(8'h4E)) begin errors++; $display("FAIL wdt_ack got %h want %h", bus.ack_data, ack_exp(8'h4E)); end

        send_byte(8'h60, 1'b0, s3, s4, n);
        trips = 0; st100 = 1'b0; tr100 = 1'b1;
        for (n = 11; n <= 96; n++) begin
            @(posedge sys_clk); #1;
            if (bus.wdt_trip) trips++;
        end
        @(negedge sys_clk);
        bus.rx_data = 8'h60; bus.rx_finish = 1'b1;
        for (n = 97; n <= 104; n++) begin
            @(posedge sys_clk); #1;
            if (bus.wdt_trip) trips++;
            if (n == 100) begin st100 = bus.cmd_strobe; tr100 = bus.wdt_trip; end
        end
        @(negedge sys_clk);
        bus.rx_finish = 1'b0;
        for (n = 105; n <= 130; n++) begin
            @(posedge sys_clk); #1;
            if (bus.wdt_trip) trips++;
        end
        checks++; if (st100 !== 1'b1 || tr100 !== 1'b0) begin
            errors++; $display("FAIL wdt_race got strobe %b trip %b want 1 0", st100, tr100); end
        checks++; if (trips !== 0 || bus.direction !== 2'b11) begin
            errors++; $display("FAIL wdt_rearm got %0d trips dir %b want 0 11", trips, bus.direction); end
        send_byte(8'h20, 1'b0, s3, s4, n);
        trips = 0;
        repeat (150) begin
            @(posedge sys_clk); #1;
            if (bus.wdt_trip) trips++;
        end
        checks++; if (trips !== 0 || bus.direction !== 2'b01) begin
            errors++; $display("FAIL wdt_hold got %0d trips dir %b want 0 01", trips, bus.direction); end
    endtask

    task automatic test_ack;
        logic s3, s4; int n;
        bus.ack_ready = 1'b0;
        send_byte(8'h14, 1'b0, s3, s4, n);
        send_byte(8'h6C, 1'b0, s3, s4, n);
        checks++; if (bus.ack_valid !== ACK_ON || bus.ack_data !== ack_exp(8'hC5)) begin
            errors++; $display("FAIL ack_hold got %b/%h want %b/%h", bus.ack_valid, bus.ack_data, ACK_ON, ack_exp(8'hC5)); end
        @(negedge sys_clk);
        bus.ack_ready = 1'b1;
        @(negedge sys_clk);
        bus.ack_ready = 1'b0;
        @(posedge sys_clk); #1;
        checks++; if (bus.ack_valid !== 1'b0) begin errors++; $display("FAIL ack_clear got %b want 0", bus.ack_valid); end
    endtask

    task automatic test_async_reset;
        logic s3, s4; int n;
        send_byte(8'h6C, 1'b0, s3, s4, n);
        send_byte(8'h01, 1'b0, s3, s4, n);
        @(posedge sys_clk); #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.angle !== 8'd225 || bus.direction !== 2'b01 || bus.ack_valid !== 1'b0) begin
            errors++; $display("FAIL arst_values got %0d/%b/%b want 225/01/0", bus.angle, bus.direction, bus.ack_valid); end
        @(negedge sys_clk);
        rst_n = 1'b1;
        send_byte(8'h10, 1'b0, s3, s4, n);
        checks++; if (n !== 1 || bus.angle !== 8'd225 || bus.direction !== 2'b01) begin
            errors++; $display("FAIL arst_prefix got %0d/%0d/%b want 1/225/01", n, bus.angle, bus.direction); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_relative();
        test_saturation();
        test_absolute();
        test_error();
        test_watchdog();
        test_ack();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
